// File: rtl/ws2811_frame_sequencer.sv
// WS2811 frame sequencer: streams PIXEL_COUNT words from a synchronous pixel memory
// to the bit transmitter, then holds the latch gap. Optional macro: WS2811_GRB_ORDER_EN.
module ws2811_frame_sequencer #(
    parameter int unsigned CLOCK_SPEED = 50_000_000,
    parameter int unsigned PIXEL_COUNT = 50,
    parameter int unsigned RESET_US    = 60,
    parameter int unsigned ADDR_WIDTH  = 10
) (
    input  logic                  clkIN,
    input  logic                  nResetIN,
    input  logic                  frameStartIN,
    output logic [ADDR_WIDTH-1:0] pixAddrOUT,
    input  logic [23:0]           pixDataIN,
    output logic                  txStartOUT,
    output logic [23:0]           txDataOUT,
    input  logic                  txBusyIN,
    output logic                  busyOUT,
    output logic                  doneOUT
);

    localparam int unsigned RESET_CYCLES = (CLOCK_SPEED / 1_000_000) * RESET_US;
    localparam int unsigned GAP_W        = $clog2(RESET_CYCLES + 1);
    localparam logic [GAP_W-1:0]      GAP_LOAD = GAP_W'(RESET_CYCLES - 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(PIXEL_COUNT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_READ,
        S_SEND,
        S_WAIT,
        S_LATCH
    } state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_pixIdx;
    logic [GAP_W-1:0]      r_gapCnt;
    logic                  r_txStart;
    logic [23:0]           r_txData;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_held;
    logic [23:0]           w_txWord;

`ifdef WS2811_GRB_ORDER_EN
    assign w_txWord = {pixDataIN[15:8], pixDataIN[23:16], pixDataIN[7:0]};
`else
    assign w_txWord = pixDataIN;
`endif

    always_ff @(posedge clkIN or negedge nResetIN) begin
        if (!nResetIN) begin
            r_state   <= S_IDLE;
            r_pixIdx  <= '0;
            r_gapCnt  <= '0;
            r_txStart <= 1'b0;
            r_txData  <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_held    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (frameStartIN) begin
                        r_pixIdx <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    r_held  <= 1'b0;
                    r_state <= S_READ;
                end
                S_READ: begin
                    // Capture once; a still-busy transmitter (possibly stale from before reset) only delays the start.
                    if (!r_held) begin
                        r_txData <= w_txWord;
                        r_held   <= 1'b1;
                    end
                    if (!txBusyIN) begin
                        r_txStart <= 1'b1;
                        r_state   <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (txBusyIN) begin
                        r_txStart <= 1'b0;
                        r_state   <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (!txBusyIN) begin
                        if (r_pixIdx < LAST_IDX) begin
                            r_pixIdx <= r_pixIdx + 1'b1;
                            r_state  <= S_FETCH;
                        end else begin
                            r_gapCnt <= GAP_LOAD;
                            r_state  <= S_LATCH;
                        end
                    end
                end
                S_LATCH: begin
                    if (r_gapCnt == '0) begin
                        r_done   <= 1'b1;
                        r_busy   <= 1'b0;
                        r_pixIdx <= '0;
                        r_state  <= S_IDLE;
                    end else begin
                        r_gapCnt <= r_gapCnt - 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign pixAddrOUT = r_pixIdx;
    assign txStartOUT = r_txStart;
    assign txDataOUT  = r_txData;
    assign busyOUT    = r_busy;
    assign doneOUT    = r_done;

endmodule
